// File: rtl/nco_sweep_pkg.sv
// Shared widths, FSM state encodings and the saturating step helper for the NCO sweep controller.
// Optional triangle sweep is selected in the top level with NCO_SWEEP_TRIANGLE_EN.
package nco_sweep_pkg;

  localparam int PHI_W_DEF   = 32;
  localparam int DWELL_W_DEF = 24;
  localparam int CALC_W      = 64;

  typedef logic [1:0] sweep_state_t;

  localparam sweep_state_t ST_IDLE  = 2'd0;
  localparam sweep_state_t ST_DWELL = 2'd1;
  localparam sweep_state_t ST_STEP  = 2'd2;
  localparam sweep_state_t ST_END   = 2'd3;

  // Operands arrive zero-extended from PHI_W (< CALC_W), so the spare upper bits
  // hold the carry of an up step; a borrow shows up as step > cur.
  function automatic logic [CALC_W-1:0] clamp_step(
    input logic [CALC_W-1:0] cur,
    input logic [CALC_W-1:0] step,
    input logic [CALC_W-1:0] bound,
    input logic              dir_down
  );
    logic [CALC_W-1:0] nxt;
    logic [CALC_W-1:0] res;
    nxt = '0;
    res = bound;
    if (dir_down) begin
      if (step <= cur) begin
        nxt = cur - step;
        res = (nxt < bound) ? bound : nxt;
      end
    end else begin
      nxt = cur + step;
      res = (nxt > bound) ? bound : nxt;
    end
    return res;
  endfunction

endpackage

// File: rtl/nco_sweep_dwell_cnt.sv
// Loadable dwell down-counter; a zero load is treated as one cycle and o_tc marks the last dwell cycle.
module nco_sweep_dwell_cnt #(
  parameter int DWELL_W = 24
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_en,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic               o_tc
);

  logic [DWELL_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
    end else if (i_en && (r_cnt > DWELL_W'(1))) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt <= DWELL_W'(1));

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep scheduler driving the NCO phase increment from start to stop word in clamped steps.
// Define NCO_SWEEP_TRIANGLE_EN to make continuous mode bounce between the end words instead of reloading.
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int PHI_W   = PHI_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               abort,
  input  logic               cont,
  input  logic [PHI_W-1:0]   start_inc,
  input  logic [PHI_W-1:0]   stop_inc,
  input  logic [PHI_W-1:0]   step_inc,
  input  logic [DWELL_W-1:0] dwell_cyc,
  output logic [PHI_W-1:0]   phi_inc,
  output logic               phi_upd,
  output logic               nco_clken,
  output logic               busy,
  output logic               done,
  output sweep_state_t       dbg_state
);

  sweep_state_t       r_state;
  logic [PHI_W-1:0]   r_phi;
  logic               r_upd;
  logic               r_busy;
  logic               r_done;
  logic               r_cont;
  logic               r_dir;
  logic [PHI_W-1:0]   r_start;
  logic [PHI_W-1:0]   r_stop;
  logic [PHI_W-1:0]   r_step;
  logic [DWELL_W-1:0] r_dwell;

  logic               w_launch;
  logic               w_load;
  logic               w_tc;
  logic [DWELL_W-1:0] w_dwell_ld;
  logic [PHI_W-1:0]   w_next;

  assign w_launch   = (r_state == ST_IDLE) && start && !abort;
  assign w_load     = w_launch
                    || ((r_state == ST_STEP) && !abort)
                    || ((r_state == ST_END) && r_cont && !abort);
  assign w_dwell_ld = (r_state == ST_IDLE) ? dwell_cyc : r_dwell;
  assign w_next     = PHI_W'(clamp_step(CALC_W'(r_phi), CALC_W'(r_step), CALC_W'(r_stop), r_dir));

`ifdef NCO_SWEEP_TRIANGLE_EN
  logic [PHI_W-1:0] w_turn;
  // The old start word becomes the new bound, heading the opposite way.
  assign w_turn = PHI_W'(clamp_step(CALC_W'(r_phi), CALC_W'(r_step), CALC_W'(r_start), ~r_dir));
`endif

  nco_sweep_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_load  (w_load),
    .i_en    (r_state == ST_DWELL),
    .i_dwell (w_dwell_ld),
    .o_tc    (w_tc)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
      r_phi   <= '0;
      r_upd   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cont  <= 1'b0;
      r_dir   <= 1'b0;
      r_start <= '0;
      r_stop  <= '0;
      r_step  <= '0;
      r_dwell <= '0;
    end else begin
      r_upd  <= 1'b0;
      r_done <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_launch) begin
              r_cont  <= cont;
              r_start <= start_inc;
              r_stop  <= stop_inc;
              r_step  <= step_inc;
              r_dwell <= dwell_cyc;
              r_dir   <= (start_inc > stop_inc);
              r_phi   <= start_inc;
              r_upd   <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= ST_DWELL;
            end
          end
          ST_DWELL: begin
            if (w_tc) begin
              if ((r_step == '0) || (r_phi == r_stop)) begin
                r_state <= ST_END;
              end else begin
                r_phi   <= w_next;
                r_upd   <= 1'b1;
                r_state <= ST_STEP;
              end
            end
          end
          ST_STEP: begin
            r_state <= ST_DWELL;
          end
          ST_END: begin
            if (r_cont) begin
`ifdef NCO_SWEEP_TRIANGLE_EN
              r_start <= r_stop;
              r_stop  <= r_start;
              r_dir   <= ~r_dir;
              r_phi   <= w_turn;
`else
              r_phi   <= r_start;
`endif
              r_upd   <= 1'b1;
              r_state <= ST_DWELL;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign phi_inc   = r_phi;
  assign phi_upd   = r_upd;
  assign busy      = r_busy;
  assign nco_clken = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl: sweep word sequences, hold times, clamping, abort and reset.
// Continuous-mode expectations follow NCO_SWEEP_TRIANGLE_EN when it is defined.
module tb_nco_sweep_ctrl;

  logic        sys_clk;
  logic        sys_rst;
  logic        start;
  logic        abort;
  logic        cont;
  logic [31:0] start_inc;
  logic [31:0] stop_inc;
  logic [31:0] step_inc;
  logic [23:0] dwell_cyc;
  logic [31:0] phi_inc;
  logic        phi_upd;
  logic        nco_clken;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  int          exp_t[$];
  logic [31:0] got_w[$];
  int          got_t[$];

  nco_sweep_ctrl #(.PHI_W(32), .DWELL_W(24)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .abort     (abort),
    .cont      (cont),
    .start_inc (start_inc),
    .stop_inc  (stop_inc),
    .step_inc  (step_inc),
    .dwell_cyc (dwell_cyc),
    .phi_inc   (phi_inc),
    .phi_upd   (phi_upd),
    .nco_clken (nco_clken),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // driver tasks
  task automatic start_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [23:0] d, input logic c);
    start_inc = s;
    stop_inc  = e;
    step_inc  = st;
    dwell_cyc = d;
    cont      = c;
    abort     = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Records (word, cycle) on each phi_upd; scrambles config inputs and pokes start mid-run.
  task automatic run_capture(input int max_words, input int budget, output int t_done,
                             output logic timed_out);
    got_w.delete();
    got_t.delete();
    timed_out = 1'b1;
    t_done    = -1;
    for (int c = 0; c < budget; c++) begin
      if (phi_upd) begin
        got_w.push_back(phi_inc);
        got_t.push_back(c);
      end
      if (done) begin
        t_done    = c;
        timed_out = 1'b0;
        break;
      end
      if ((max_words > 0) && (got_w.size() >= max_words)) begin
        timed_out = 1'b0;
        break;
      end
      start     = (c == 3);
      start_inc = $urandom;
      stop_inc  = $urandom;
      step_inc  = $urandom;
      dwell_cyc = 24'($urandom_range(0, 9));
      cont      = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    start = 1'b0; abort = 1'b0; cont = 1'b0;
    start_inc = '0; stop_inc = '0; step_inc = '0; dwell_cyc = '0;
    tick();
    tick();
    tests_run++;
    if (phi_inc !== 32'd0) begin tests_failed++; $display("FAIL reset phi_inc: got %0d expected 0", phi_inc); end
    tests_run++;
    if (phi_upd !== 1'b0) begin tests_failed++; $display("FAIL reset phi_upd: got %b expected 0", phi_upd); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy: got %b expected 0", busy); end
    tests_run++;
    if (nco_clken !== 1'b0) begin tests_failed++; $display("FAIL reset nco_clken: got %b expected 0", nco_clken); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset done: got %b expected 0", done); end
    tests_run++;
    if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset state: got %0d expected 0", dbg_state); end
    sys_rst = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release busy: got %b expected 0", busy); end
  endtask

  // Single sweep; exp_q holds the hand-computed word sequence.
  task automatic test_single(input string name, input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] st, input logic [23:0] d);
    int   dd;
    int   t_done;
    int   n;
    int   exp_gap;
    logic to;
    dd = (d == 24'd0) ? 1 : int'(d);
    start_sweep(s, e, st, d, 1'b0);
    tests_run++;
    if (phi_inc !== s || phi_upd !== 1'b1 || busy !== 1'b1 || nco_clken !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s launch: got phi=%0h upd=%b busy=%b clken=%b expected phi=%0h upd=1 busy=1 clken=1",
               name, phi_inc, phi_upd, busy, nco_clken, s);
    end
    run_capture(0, 400, t_done, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL %s timeout: got no done expected done within 400 cycles", name); end
    tests_run++;
    if (got_w.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s word_count: got %0d expected %0d", name, got_w.size(), exp_q.size());
    end
    n = (got_w.size() < exp_q.size()) ? got_w.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (got_w[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL %s word[%0d]: got %0h expected %0h", name, i, got_w[i], exp_q[i]);
      end
      if (i > 0) begin
        tests_run++;
        if ((got_t[i] - got_t[i-1]) !== ((i == 1) ? dd : dd + 1)) begin
          tests_failed++;
          $display("FAIL %s hold[%0d]: got %0d expected %0d", name, i - 1, got_t[i] - got_t[i-1],
                   (i == 1) ? dd : dd + 1);
        end
      end
    end
    if (!to && (got_t.size() > 0)) begin
      exp_gap = (exp_q.size() > 1) ? dd + 2 : dd + 1;
      tests_run++;
      if ((t_done - got_t[got_t.size()-1]) !== exp_gap) begin
        tests_failed++;
        $display("FAIL %s done_gap: got %0d expected %0d", name, t_done - got_t[got_t.size()-1], exp_gap);
      end
      tests_run++;
      if (busy !== 1'b0 || nco_clken !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s busy_at_done: got busy=%b clken=%b expected 0 0", name, busy, nco_clken);
      end
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || phi_inc !== exp_q[exp_q.size()-1]) begin
      tests_failed++;
      $display("FAIL %s after_done: got done=%b busy=%b phi=%0h expected done=0 busy=0 phi=%0h",
               name, done, busy, phi_inc, exp_q[exp_q.size()-1]);
    end
  endtask

  task automatic test_continuous();
    int   t_done;
    logic to;
    exp_q.delete();
    exp_t.delete();
`ifdef NCO_SWEEP_TRIANGLE_EN
    exp_q = '{32'd1000, 32'd1100, 32'd1200, 32'd1100, 32'd1000, 32'd1100};
    exp_t = '{2, 3, 4, 2, 4};
`else
    exp_q = '{32'd1000, 32'd1100, 32'd1200, 32'd1000, 32'd1100, 32'd1200};
    exp_t = '{2, 3, 4, 2, 3};
`endif
    start_sweep(32'd1000, 32'd1200, 32'd100, 24'd2, 1'b1);
    run_capture(6, 200, t_done, to);
    tests_run++;
    if (t_done !== -1 || to) begin
      tests_failed++;
      $display("FAIL cont no_done: got done_at=%0d timeout=%b expected done_at=-1 timeout=0", t_done, to);
    end
    tests_run++;
    if (got_w.size() !== 6) begin tests_failed++; $display("FAIL cont word_count: got %0d expected 6", got_w.size()); end
    for (int i = 0; i < 6 && i < got_w.size(); i++) begin
      tests_run++;
      if (got_w[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL cont word[%0d]: got %0d expected %0d", i, got_w[i], exp_q[i]);
      end
      if (i > 0) begin
        tests_run++;
        if ((got_t[i] - got_t[i-1]) !== exp_t[i-1]) begin
          tests_failed++;
          $display("FAIL cont hold[%0d]: got %0d expected %0d", i - 1, got_t[i] - got_t[i-1], exp_t[i-1]);
        end
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int   t_done;
    logic to;
    start_sweep(32'd1000, 32'd1200, 32'd100, 24'd2, 1'b1);
    run_capture(3, 100, t_done, to);
    tests_run++;
    if (got_w.size() !== 3) begin tests_failed++; $display("FAIL abort reach_point3: got %0d points expected 3", got_w.size()); end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || nco_clken !== 1'b0 || done !== 1'b1 || phi_inc !== 32'd1200 || phi_upd !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort edge: got busy=%b clken=%b done=%b phi=%0d upd=%b expected 0 0 1 1200 0",
               busy, nco_clken, done, phi_inc, phi_upd);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || phi_inc !== 32'd1200) begin
      tests_failed++;
      $display("FAIL abort after: got done=%b busy=%b phi=%0d expected 0 0 1200", done, busy, phi_inc);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL abort_idle done: got %b expected 0", done); end
  endtask

  task automatic test_start_abort_idle();
    start_inc = 32'd5555; stop_inc = 32'd6000; step_inc = 32'd10; dwell_cyc = 24'd1; cont = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || nco_clken !== 1'b0 || phi_upd !== 1'b0 || done !== 1'b0 || phi_inc !== 32'd1200) begin
      tests_failed++;
      $display("FAIL start_abort: got busy=%b clken=%b upd=%b done=%b phi=%0d expected 0 0 0 0 1200",
               busy, nco_clken, phi_upd, done, phi_inc);
    end
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b0 || phi_inc !== 32'd1200) begin
      tests_failed++;
      $display("FAIL start_abort later: got busy=%b phi=%0d expected 0 1200", busy, phi_inc);
    end
  endtask

  task automatic test_reset_mid();
    start_sweep(32'd2000, 32'd2400, 32'd100, 24'd5, 1'b0);
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    tests_run++;
    if (phi_inc !== 32'd0 || phi_upd !== 1'b0 || busy !== 1'b0 || nco_clken !== 1'b0 || done !== 1'b0
        || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: got phi=%0d upd=%b busy=%b clken=%b done=%b state=%0d expected all 0",
               phi_inc, phi_upd, busy, nco_clken, done, dbg_state);
    end
    sys_rst = 1'b0;
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid release: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  initial begin
    test_reset();

    exp_q = '{32'd1000, 32'd1100, 32'd1200, 32'd1300};
    test_single("up_basic", 32'd1000, 32'd1300, 32'd100, 24'd3);
    exp_q = '{32'd1000, 32'd1100, 32'd1200, 32'd1250};
    test_single("up_clamp", 32'd1000, 32'd1250, 32'd100, 24'd3);
    exp_q = '{32'd1300, 32'd1100, 32'd1000};
    test_single("down", 32'd1300, 32'd1000, 32'd200, 24'd2);
    exp_q = '{32'hFFFF_FF00, 32'hFFFF_FFFF};
    test_single("carry", 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 24'd1);
    exp_q = '{32'd500};
    test_single("step0_dwell0", 32'd500, 32'd900, 32'd0, 24'd0);
    exp_q = '{32'd700};
    test_single("equal_words", 32'd700, 32'd700, 32'd10, 24'd2);

    test_continuous();
    test_abort();
    test_start_abort_idle();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
